// File: rtl/offchip_mem_responder.sv
// offchip_mem_responder
//
// Synthesizable stand-in for the off-chip memory that an HLS-generated
// accelerator expects on its master memory bus. Each channel is one byte lane
// with its own address. All channels share one byte array. Reads return data
// after READ_DELAY cycles. Writes complete after WRITE_DELAY cycles. Slave-side
// data and ready from the accelerator are ORed into the returned signals.
//
// Ports
//   clock               rising-edge clock
//   reset               synchronous, active-high; clears counters, delay lines
//                       and the conflict flag (memory contents are kept)
//   Mout_oe_ram[k]      read enable, channel k
//   Mout_we_ram[k]      write enable, channel k
//   Mout_addr_ram       absolute byte address, channel k at [k*ADDR_W +: ADDR_W]
//   Mout_Wdata_ram      write byte, channel k at [k*8 +: 8]
//   Mout_data_ram_size  access width in bits (0..8), channel k at [k*4 +: 4]
//   Sout_Rdata_ram      slave read data, ORed into M_Rdata_ram
//   Sout_DataRdy        slave ready, ORed into M_DataRdy
//   M_Rdata_ram         read data returned to the accelerator
//   M_DataRdy           per-channel access-complete strobe
//   init_we/addr/data   backdoor byte load, offset relative to BASE_ADDR
//   err_conflict        sticky flag: some channel drove oe and we together
module offchip_mem_responder #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 7,
  parameter int MEMSIZE     = 64,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        Mout_oe_ram,
  input  logic [CHANNELS-1:0]        Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram,
  input  logic [CHANNELS*8-1:0]      Mout_Wdata_ram,
  input  logic [CHANNELS*4-1:0]      Mout_data_ram_size,
  input  logic [CHANNELS*8-1:0]      Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]        Sout_DataRdy,
  output logic [CHANNELS*8-1:0]      M_Rdata_ram,
  output logic [CHANNELS-1:0]        M_DataRdy,
  input  logic                       init_we,
  input  logic [ADDR_W-1:0]          init_addr,
  input  logic [7:0]                 init_data,
  output logic                       err_conflict
);

  localparam int OFF_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int DLY_D = READ_DELAY - 1;
  localparam int MAX_D = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W = $clog2(MAX_D) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);

  // Bit mask for an access of 'size' bits; widths of 8 or more cover the byte.
  function automatic logic [7:0] size_mask(input logic [3:0] size);
    if (size >= 4'd8) return 8'hFF;
    return 8'((9'd1 << size) - 9'd1);
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] wdata,
                                            input logic [7:0] old,
                                            input logic [7:0] mask);
    return (wdata & mask) | (old & ~mask);
  endfunction

  logic [7:0]       r_mem [MEMSIZE];
  logic [CNT_W-1:0] r_cnt [CHANNELS];
  logic [7:0]       r_dly [CHANNELS][DLY_D];
  logic             r_err;

  int               w_addr_i [CHANNELS];
  logic [OFF_W-1:0] w_idx    [CHANNELS];
  logic [7:0]       w_wbyte  [CHANNELS];
  logic [7:0]       w_cap    [CHANNELS];
  logic [CHANNELS-1:0] w_inr, w_rd, w_wr, w_conf;
  logic             w_init_ok;
  logic [OFF_W-1:0] w_init_idx;

  // Per-channel decode. A conflicting channel is neither a read nor a write.
  always_comb begin
    w_inr = '0;
    w_rd  = '0;
    w_wr  = '0;
    w_conf = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_addr_i[k] = int'(Mout_addr_ram[k*ADDR_W +: ADDR_W]);
      w_inr[k]    = (w_addr_i[k] >= BASE_ADDR) && (w_addr_i[k] < BASE_ADDR + MEMSIZE);
      w_idx[k]    = OFF_W'(w_addr_i[k] - BASE_ADDR);
      w_conf[k]   = Mout_oe_ram[k] & Mout_we_ram[k];
      w_rd[k]     = Mout_oe_ram[k] & ~Mout_we_ram[k] & w_inr[k];
      w_wr[k]     = Mout_we_ram[k] & ~Mout_oe_ram[k] & w_inr[k];
      w_wbyte[k]  = merge_byte(Mout_Wdata_ram[k*8 +: 8], r_mem[w_idx[k]],
                               size_mask(Mout_data_ram_size[k*4 +: 4]));
      // Anything but an in-range read feeds zero into the delay line.
      w_cap[k]    = w_rd[k] ? r_mem[w_idx[k]] : 8'h00;
    end
    w_init_ok  = init_we && (int'(init_addr) < MEMSIZE);
    w_init_idx = OFF_W'(init_addr);
  end

  always_comb begin
    M_Rdata_ram = '0;
    M_DataRdy   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      M_Rdata_ram[k*8 +: 8] = r_dly[k][0] | Sout_Rdata_ram[k*8 +: 8];
      M_DataRdy[k] = Sout_DataRdy[k]
                   | (w_rd[k] && (r_cnt[k] == RD_LAST))
                   | (w_wr[k] && (r_cnt[k] == WR_LAST));
    end
  end

  assign err_conflict = r_err;

  // Control: latency counters, read delay lines, sticky conflict flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_cnt[k] <= '0;
        for (int i = 0; i < DLY_D; i++) r_dly[k][i] <= 8'h00;
      end
    end else begin
      if (|w_conf) r_err <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        // The counter wraps after the ready cycle, so an access that stays
        // asserted starts over as a new back-to-back access.
        if (w_rd[k])
          r_cnt[k] <= (r_cnt[k] < RD_LAST) ? r_cnt[k] + CNT_W'(1) : '0;
        else if (w_wr[k])
          r_cnt[k] <= (r_cnt[k] < WR_LAST) ? r_cnt[k] + CNT_W'(1) : '0;
        else
          r_cnt[k] <= '0;
        // Data enters at the tail and reaches stage 0 in the ready cycle.
        for (int i = 0; i < DLY_D - 1; i++) r_dly[k][i] <= r_dly[k][i+1];
        r_dly[k][DLY_D-1] <= w_cap[k];
      end
    end
  end

  // Backing store, not reset. Later assignments win: the backdoor load first,
  // then channels in ascending order, so the highest channel index takes a
  // shared offset. Reads in the same cycle see the pre-edge byte.
  always_ff @(posedge clock) begin
    if (w_init_ok) r_mem[w_init_idx] <= init_data;
    for (int k = 0; k < CHANNELS; k++)
      if (w_wr[k]) r_mem[w_idx[k]] <= w_wbyte[k];
  end

endmodule

// File: tb/tb_offchip_mem_responder.sv
`timescale 1ns/1ps
module tb_offchip_mem_responder;
  localparam int CH = 2, AW = 7, MS = 64, BASE = 0, RD = 2, WD = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [CH-1:0]     Mout_oe_ram, Mout_we_ram;
  logic [CH*AW-1:0]  Mout_addr_ram;
  logic [CH*8-1:0]   Mout_Wdata_ram;
  logic [CH*4-1:0]   Mout_data_ram_size;
  logic [CH*8-1:0]   Sout_Rdata_ram;
  logic [CH-1:0]     Sout_DataRdy;
  logic [CH*8-1:0]   M_Rdata_ram;
  logic [CH-1:0]     M_DataRdy;
  logic              init_we;
  logic [AW-1:0]     init_addr;
  logic [7:0]        init_data;
  logic              err_conflict;

  always #5 clock = ~clock;

  offchip_mem_responder #(
    .CHANNELS(CH), .ADDR_W(AW), .MEMSIZE(MS), .BASE_ADDR(BASE),
    .READ_DELAY(RD), .WRITE_DELAY(WD)
  ) dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
    .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .err_conflict(err_conflict)
  );

  typedef struct {
    logic          oe;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [3:0]    size;
  } op_t;

  typedef struct {
    int         cyc;
    bit         chk;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq [CH][$];
  exp_t       mon_e;
  logic [7:0] mm [2**AW];
  int         cyc = 0;
  int         errs = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  bit         exp_err = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Sticky conflict flag as described: set after any oe&we edge, cleared by reset.
  always @(posedge clock)
    if (reset) exp_err <= 1'b0;
    else if (|(Mout_oe_ram & Mout_we_ram)) exp_err <= 1'b1;

  // Monitor: every ready strobe must match the head of its channel's queue.
  always @(negedge clock) if (mon_en) begin
    checks++;
    if (err_conflict !== exp_err) begin
      errs++;
      $display("FAIL err_conflict cyc=%0d got=%b exp=%b", cyc, err_conflict, exp_err);
    end
    for (int k = 0; k < CH; k++) begin
      while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
        mon_e = sbq[k].pop_front();
        checks++; errs++;
        $display("FAIL overdue_ready ch%0d cyc=%0d got=none exp_cyc=%0d", k, cyc, mon_e.cyc);
      end
      if (sbq[k].size() > 0 && sbq[k][0].cyc == cyc) begin
        mon_e = sbq[k].pop_front();
        checks++;
        if (M_DataRdy[k] !== 1'b1) begin
          errs++;
          $display("FAIL ready ch%0d cyc=%0d got=%b exp=1", k, cyc, M_DataRdy[k]);
        end else if (mon_e.chk && M_Rdata_ram[k*8 +: 8] !== mon_e.data) begin
          errs++;
          $display("FAIL rdata ch%0d cyc=%0d got=%02h exp=%02h", k, cyc, M_Rdata_ram[k*8 +: 8], mon_e.data);
        end
      end else if (M_DataRdy[k] !== 1'b0) begin
        checks++; errs++;
        $display("FAIL spurious_ready ch%0d cyc=%0d got=%b exp=0", k, cyc, M_DataRdy[k]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic op_t mk(input bit oe, input bit we, input int a, input int d, input int s);
    op_t o;
    o.oe = oe; o.we = we; o.addr = AW'(a); o.wdata = 8'(d); o.size = 4'(s);
    return o;
  endfunction

  function automatic bit in_rng(input logic [AW-1:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + MS);
  endfunction

  function automatic logic [7:0] ref_mask(input logic [3:0] s);
    int v;
    v = (s >= 4'd8) ? 255 : (1 << s) - 1;
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_ch(input int k, input op_t o);
    Mout_oe_ram[k] = o.oe;
    Mout_we_ram[k] = o.we;
    Mout_addr_ram[k*AW +: AW] = o.addr;
    Mout_Wdata_ram[k*8 +: 8] = o.wdata;
    Mout_data_ram_size[k*4 +: 4] = o.size;
  endtask

  task automatic drive_idle();
    Mout_oe_ram = '0; Mout_we_ram = '0; init_we = 1'b0;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%02h exp=%02h", name, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input int k, input int c, input bit chk, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.chk = chk; e.data = d;
    sbq[k].push_back(e);
  endtask

  // Issue one access per channel starting this cycle; reads are held RD cycles,
  // writes WD cycles. The reference memory is updated as of the end of cycle 0.
  task automatic issue(input op_t o0, input op_t o1, input bit ie,
                       input logic [AW-1:0] ia, input logic [7:0] id);
    op_t o [CH];
    int  len [CH];
    int  L;
    logic [AW-1:0] off;
    logic [7:0] m;
    o[0] = o0; o[1] = o1; L = 1;
    for (int k = 0; k < CH; k++) begin
      len[k] = 1;
      if (o[k].oe && !o[k].we) len[k] = RD;
      else if (o[k].we && !o[k].oe) len[k] = WD;
      if (len[k] > L) L = len[k];
    end
    for (int k = 0; k < CH; k++) begin
      off = o[k].addr - AW'(BASE);
      if (in_rng(o[k].addr) && o[k].oe && !o[k].we)
        push_exp(k, cyc + RD - 1, 1'b1, mm[off] | Sout_Rdata_ram[k*8 +: 8]);
      else if (in_rng(o[k].addr) && o[k].we && !o[k].oe)
        push_exp(k, cyc + WD - 1, 1'b0, 8'h00);
    end
    if (ie && int'(ia) < MS) mm[ia] = id;
    for (int k = 0; k < CH; k++) begin
      off = o[k].addr - AW'(BASE);
      m = ref_mask(o[k].size);
      if (in_rng(o[k].addr) && o[k].we && !o[k].oe)
        mm[off] = (o[k].wdata & m) | (mm[off] & ~m);
    end
    for (int c = 0; c < L; c++) begin
      for (int k = 0; k < CH; k++)
        set_ch(k, (c < len[k]) ? o[k] : mk(0, 0, 0, 0, 0));
      init_we = ie && (c == 0); init_addr = ia; init_data = id;
      tick();
    end
    drive_idle();
  endtask

  op_t IDLE, a, b;
  bit  ie;

  function automatic op_t rnd_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 8)       return mk(1, 0, $urandom_range(0, 71), 0, 0);
    else if (r < 16) return mk(0, 1, $urandom_range(0, 71), $urandom_range(0, 255), $urandom_range(0, 10));
    else if (r < 19) return mk(0, 0, 0, 0, 0);
    else             return mk(1, 1, $urandom_range(0, 71), $urandom_range(0, 255), 8);
  endfunction

  initial begin
    IDLE = mk(0, 0, 0, 0, 0);
    reset = 1'b1;
    drive_idle();
    Mout_addr_ram = '0; Mout_Wdata_ram = '0; Mout_data_ram_size = '0;
    init_addr = '0; init_data = '0;
    Sout_Rdata_ram = 16'hC3A5; Sout_DataRdy = '0;
    tick();
    mon_en = 1'b1;
    @(negedge clock);
    check8("rst_rdata0", M_Rdata_ram[7:0], 8'hA5);
    check8("rst_rdata1", M_Rdata_ram[15:8], 8'hC3);
    @(posedge clock); #1;
    Sout_DataRdy = 2'b11;
    push_exp(0, cyc, 1'b1, 8'hA5);
    push_exp(1, cyc, 1'b1, 8'hC3);
    tick();
    Sout_DataRdy = '0; Sout_Rdata_ram = '0; reset = 1'b0;

    // Backdoor load of the whole array; out-of-range offsets must be ignored.
    for (int i = 0; i < MS; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      case (i)
        0: v = 8'h11;
        1: v = 8'h22;
        2: v = 8'h33;
        3: v = 8'h44;
        5: v = 8'hF0;
        default: ;
      endcase
      issue(IDLE, IDLE, 1'b1, AW'(i), v);
    end
    issue(IDLE, IDLE, 1'b1, 7'd64, 8'hEE);
    issue(IDLE, IDLE, 1'b1, 7'd127, 8'hEE);

    issue(mk(1, 0, 2, 0, 0), IDLE, 1'b0, '0, '0);          // 0x33
    issue(mk(1, 0, 0, 0, 0), mk(1, 0, 3, 0, 0), 1'b0, '0, '0);  // 0x11, 0x44
    issue(IDLE, mk(0, 1, 5, 'hAB, 4), 1'b0, '0, '0);
    issue(IDLE, mk(1, 0, 5, 0, 0), 1'b0, '0, '0);          // 0xFB
    issue(mk(0, 1, 7, 'h01, 8), mk(0, 1, 7, 'h02, 8), 1'b0, '0, '0);
    issue(mk(1, 0, 7, 0, 0), IDLE, 1'b0, '0, '0);          // 0x02
    issue(mk(1, 0, 7, 0, 0), mk(0, 1, 7, 'h55, 8), 1'b0, '0, '0);  // old 0x02
    issue(mk(1, 0, 7, 0, 0), IDLE, 1'b0, '0, '0);          // 0x55
    issue(IDLE, mk(0, 1, 9, 'h66, 8), 1'b1, 7'd9, 8'h99);
    issue(mk(0, 1, 10, 'hFF, 0), mk(0, 1, 11, 'h3C, 12), 1'b0, '0, '0);
    issue(mk(1, 0, 9, 0, 0), mk(1, 0, 10, 0, 0), 1'b0, '0, '0);
    issue(IDLE, mk(1, 0, 11, 0, 0), 1'b0, '0, '0);

    // Out-of-range read: only the slave terms may show up.
    Sout_Rdata_ram[7:0] = 8'h5A;
    set_ch(0, mk(1, 0, 64, 0, 0));
    tick();
    Sout_DataRdy[0] = 1'b1;
    push_exp(0, cyc, 1'b1, 8'h5A);
    tick();
    Sout_DataRdy = '0; Sout_Rdata_ram = '0; drive_idle();
    tick();

    // Conflict: flag rises next cycle, memory untouched, flag sticks.
    issue(mk(1, 1, 3, 'h00, 8), IDLE, 1'b0, '0, '0);
    issue(mk(1, 0, 3, 0, 0), IDLE, 1'b0, '0, '0);          // 0x44
    repeat (3) tick();

    // Reset in cycle 0 of a read: no ready, delay line cleared, flag cleared.
    reset = 1'b1;
    set_ch(0, mk(1, 0, 1, 0, 0));
    tick();
    reset = 1'b0;
    Sout_Rdata_ram[7:0] = 8'h3C;
    @(negedge clock);
    check8("rst_mid_rdata", M_Rdata_ram[7:0], 8'h3C);
    @(posedge clock); #1;
    drive_idle(); Sout_Rdata_ram = '0;
    tick();
    issue(mk(1, 0, 1, 0, 0), IDLE, 1'b0, '0, '0);          // 0x22 kept

    for (int it = 0; it < 400; it++) begin
      a = rnd_op();
      b = rnd_op();
      ie = ($urandom_range(0, 7) == 0);
      issue(a, b, ie, AW'($urandom_range(0, 127)), 8'($urandom));
    end

    repeat (4) tick();
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (sbq[k].size() != 0) begin
        errs++;
        $display("FAIL pending_ready ch%0d got=%0d exp=0", k, sbq[k].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/offchip_mem_responder.md
# offchip_mem_responder

Synthesizable off-chip memory responder that consumes the master-side memory bus of an HLS-generated `main` accelerator (`Mout_oe_ram`, `Mout_we_ram`, `Mout_addr_ram`, `Mout_Wdata_ram`, `Mout_data_ram_size`). It drives the accelerator's `M_Rdata_ram` and `M_DataRdy` inputs. It replaces the behavioural memory model of the simulation bench so that the same latency, masking and handshake rules run on FPGA or under lint-clean simulation. Each channel is one byte lane with its own address, and all channels share one byte array.

## Interface
- `CHANNELS`, 2: number of independent byte lanes/ports.
- `ADDR_W`, 7: address bits per channel.
- `MEMSIZE`, 64: bytes of backing storage (≤ 2^ADDR_W).
- `BASE_ADDR`, 0: first absolute address served.
- `READ_DELAY`, 2: read latency in cycles from `oe` to `DataRdy` (≥ 2).
- `WRITE_DELAY`, 1: write handshake latency (≥ 1).

Ports:
- `clock`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `Mout_oe_ram`  in  CHANNELS  per-channel read enable.
- `Mout_we_ram`  in  CHANNELS  per-channel write enable.
- `Mout_addr_ram`  in  CHANNELS*ADDR_W  per-channel absolute byte address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- `Mout_Wdata_ram`  in  CHANNELS*8  per-channel write byte.
- `Mout_data_ram_size`  in  CHANNELS*4  per-channel access width in bits (0..8).
- `Sout_Rdata_ram`  in  CHANNELS*8  slave read data from the accelerator, ORed into the output.
- `Sout_DataRdy`  in  CHANNELS  slave ready from the accelerator, ORed into the output.
- `M_Rdata_ram`  out  CHANNELS*8  read data returned to the accelerator.
- `M_DataRdy`  out  CHANNELS  per-channel access-complete strobe.
- `init_we`  in  1  backdoor write strobe for loading memory before start.
- `init_addr`  in  ADDR_W  backdoor offset, relative to BASE_ADDR.
- `init_data`  in  8  backdoor byte.
- `err_conflict`  out  1  sticky flag, set when `oe` and `we` are both high on one channel.

## Operation
- In-range test per channel k: `BASE_ADDR ≤ addr_k < BASE_ADDR+MEMSIZE`. Offset is `addr_k − BASE_ADDR`.
- Mask per channel: `mask = (1<<size)−1`, truncated to 8 bits. Size ≥ 8 gives 0xFF; size 0 gives 0x00.
- Write (`we`=1, `oe`=0, in range): at the rising edge, `mem[off] = (Wdata & mask) | (mem[off] & ~mask)`.
- Read (`oe`=1, `we`=0, in range):
  - The byte `mem[off]` (or 0 if out of range) enters a per-lane delay line of depth READ_DELAY−1.
  - Output stage 0 drives the lane: `M_Rdata_ram = stage0 | Sout_Rdata_ram`.
- Per-channel latency counter `cnt_k`:
  - While an in-range read is held: increments while `< READ_DELAY−1`, otherwise returns to 0.
  - While an in-range write is held: same rule with WRITE_DELAY−1.
  - Otherwise: 0.
- `M_DataRdy[k] = Sout_DataRdy[k] | (in_range_k & ((oe_k & cnt_k==READ_DELAY−1) | (we_k & cnt_k==WRITE_DELAY−1)))`.
- Out-of-range access: no write, read byte 0, no local DataRdy. The `Sout` terms still pass through.
- Conflict (`oe_k & we_k`):
  - No memory update on that channel and no local DataRdy.
  - `err_conflict` sets and stays set until reset.
- Write priority on the same offset in the same cycle: higher channel index wins over lower; any channel write wins over `init_we`.
- Read/write collision across channels on the same offset in the same cycle: the read captures the old byte.
- `init_we` writes the full byte to `mem[init_addr]` when `init_addr < MEMSIZE`. Out-of-range `init_addr` is ignored.

## Timing
- Reset values: all `cnt_k` = 0, delay lines = 0, `err_conflict` = 0.
  - Therefore `M_Rdata_ram = Sout_Rdata_ram` and `M_DataRdy = Sout_DataRdy` during and after reset until the first access.
  - Memory contents are not cleared by reset.
- Read, READ_DELAY=2:
  - Cycle 0: `oe` high, `cnt`=0, DataRdy low.
  - Cycle 1: `cnt`=1, DataRdy high, `M_Rdata_ram` holds the byte sampled at the end of cycle 0.
  - Cycle 2, if `oe` is still held: `cnt`=0 and a new access begins.
- Write, WRITE_DELAY=1: DataRdy is high combinationally in the same cycle as `we`. Memory is updated at that cycle's edge.
- Back-to-back accesses are allowed. The accelerator drops or changes `oe`/`we` in the cycle after DataRdy.
- Reset asserted mid-read: the counter and delay line clear at that edge, and no DataRdy is issued for the aborted read.
- `err_conflict` rises in the cycle after the conflicting edge.

## Test plan
- `init_we` loads offsets 0..3 with 0x11, 0x22, 0x33, 0x44. Channel 0 reads addr 2 with `oe` held 2 cycles → DataRdy in cycle 1 with `M_Rdata_ram[7:0]`=0x33.
- Channel 1 writes 0xAB with size=4 to offset 5, which holds 0xF0 → DataRdy in the same cycle; a later read returns 0xFB.
- Both channels write offset 7 in the same cycle (ch0 0x01, ch1 0x02) → read returns 0x02. Ch0 reads offset 7 while ch1 writes 0x55 to it → ch0 gets 0x02.
- Channel 0 reads addr 64, which is out of range, with `Sout_Rdata_ram`=0x5A and `Sout_DataRdy[0]`=1 → `M_Rdata_ram[7:0]`=0x5A, DataRdy from the Sout term only, no local ready.
- Channel 0 drives `oe`=`we`=1 → `err_conflict`=1 the next cycle, memory unchanged, flag held until `reset`.
- `reset` asserted in cycle 0 of a read → no DataRdy in cycle 1, `cnt` is 0, `M_Rdata_ram` equals the Sout term.
